// File: rtl/frame_pixel_writer.sv
// frame_pixel_writer
//   Captures one H_RES*V_RES frame from a non-stallable 24-bit pixel stream
//   after an arm command. Pixels are buffered in a show-ahead FIFO and written
//   one word per pixel to a memory controller over a req/ack handshake, at
//   linear addresses starting at BASE_ADDR. Pixels arriving while the FIFO is
//   full are dropped; their addresses are skipped so frame geometry holds.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 arm capture of one frame (honoured only in IDLE)
//   i_data[23:0], i_valid   pixel stream {R,G,B} with single-cycle qualifier
//   o_wr_req                write request (FIFO not empty)
//   o_wr_addr[ADDR_W-1:0]   write address of the head entry
//   o_wr_data[31:0]         {8'h00, pixel} of the head entry
//   i_wr_ack                controller accepted the current request
//   o_busy                  capture or drain in progress
//   o_frame_done            one-cycle pulse after the last write is accepted
//   o_overflow              sticky: a pixel was dropped this frame
//   o_pix_count             pixels received (accepted plus dropped) this frame
module frame_pixel_writer #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [23:0]       i_data,
   input  logic              i_valid,
   output logic              o_wr_req,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data,
   input  logic              i_wr_ack,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_overflow,
   output logic [ADDR_W-1:0] o_pix_count
);

   localparam int unsigned NPIX  = H_RES * V_RES;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = ADDR_W + 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0] count, count_nxt, remain;
   logic [ENT_W-1:0] push_entry, head_nxt;

   logic arm, take, push, drop, pop, frame_done_nxt;

   // A completed handshake pops the head; remain is the occupancy after it.
   assign pop        = (count != '0) & i_wr_ack;
   assign remain     = count - CNT_W'(pop);
   assign count_nxt  = remain + CNT_W'(push);
   assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
   assign push_entry = {ADDR_W'(BASE_ADDR) + o_pix_count, i_data};

   // Next head: the incoming pixel if nothing older survives, else storage.
   assign head_nxt   = (remain == '0) ? push_entry : mem[rd_ptr_nxt];

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and capture decisions
   always_comb begin
      state_nxt      = state;
      arm            = 1'b0;
      take           = 1'b0;
      push           = 1'b0;
      drop           = 1'b0;
      frame_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = CAPTURE;
               arm       = 1'b1;
            end
         end
         CAPTURE: begin
            if (i_valid) begin
               take = 1'b1;
               // Fullness judged on the registered count, before any same-cycle pop.
               if (count < CNT_W'(FIFO_DEPTH)) push = 1'b1;
               else                            drop = 1'b1;
               if (o_pix_count >= ADDR_W'(NPIX - 1)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Finish in the cycle right after the final ack.
            if (remain == '0) begin
               state_nxt      = IDLE;
               frame_done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO storage (no reset needed; validity tracked by count)
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // FIFO pointers, registered head presentation and status outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         o_wr_req     <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
         o_pix_count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         o_wr_req <= (count_nxt != '0);
         // Head only moves on pop or push-into-empty, so it holds while stalled.
         if (count_nxt != '0) begin
            o_wr_addr <= head_nxt[ENT_W-1:24];
            o_wr_data <= {8'h00, head_nxt[23:0]};
         end
         o_busy       <= (state_nxt != IDLE);
         o_frame_done <= frame_done_nxt;
         if (arm) begin
            o_overflow  <= 1'b0;
            o_pix_count <= '0;
         end else begin
            if (drop) o_overflow <= 1'b1;
            if (take && (o_pix_count != ADDR_W'(NPIX)))
               o_pix_count <= o_pix_count + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Bench for frame_pixel_writer with a small 4x2 frame, depth-4 FIFO, base 0x100.
module tb_frame_pixel_writer;

   localparam int H    = 4;
   localparam int V    = 2;
   localparam int NPIX = H * V;
   localparam int DEP  = 4;
   localparam int AW   = 12;
   localparam int BASE = 'h100;

   logic          clk, rst, start, valid, ack;
   logic [23:0]   data;
   logic          req, busy, done, over;
   logic [AW-1:0] addr, pcnt;
   logic [31:0]   wdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_wr_cyc = 0;
   bit done_busy = 0;
   logic [AW-1:0] la[$];
   logic [31:0]   ld[$];

   frame_pixel_writer #(
      .H_RES(H), .V_RES(V), .FIFO_DEPTH(DEP), .ADDR_W(AW), .BASE_ADDR(BASE)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(data), .i_valid(valid),
      .o_wr_req(req), .o_wr_addr(addr), .o_wr_data(wdata), .i_wr_ack(ack),
      .o_busy(busy), .o_frame_done(done), .o_overflow(over), .o_pix_count(pcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: a queue of pending writes plus frame bookkeeping.
   int            m_phase;   // 0 idle, 1 capturing, 2 draining
   logic [35:0]   m_q[$];
   int            m_idx;
   bit            m_over, m_done, m_busy;

   always @(posedge clk or posedge rst) begin : model
      int ph;
      bit pp;
      bit full;
      if (rst) begin
         m_phase = 0; m_q.delete(); m_idx = 0;
         m_over = 0; m_done = 0; m_busy = 0;
      end else begin
         ph   = m_phase;
         pp   = (m_q.size() != 0) && ack;
         full = (m_q.size() >= DEP);
         m_done = 0;
         if (ph == 0 && start) begin
            m_phase = 1; m_idx = 0; m_over = 0;
         end else if (ph == 1 && valid) begin
            if (!full) m_q.push_back({AW'(BASE + m_idx), data});
            else       m_over = 1;
            m_idx++;
            if (m_idx == NPIX) m_phase = 2;
         end
         if (pp) void'(m_q.pop_front());
         if (ph == 2 && m_q.size() == 0) begin
            m_phase = 0; m_done = 1;
         end
         m_busy = (m_phase != 0);
      end
   end

   // Write / completion monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && req && ack) begin
         la.push_back(addr); ld.push_back(wdata); last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++; done_cyc = cyc; done_busy = busy;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_cnt != d0) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++; if (req !== 1'b0)   begin errors++; $display("FAIL rst_req got %b exp 0", req); end
      checks++; if (addr !== '0)    begin errors++; $display("FAIL rst_addr got %h exp 0", addr); end
      checks++; if (wdata !== '0)   begin errors++; $display("FAIL rst_data got %h exp 0", wdata); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (over !== 1'b0)  begin errors++; $display("FAIL rst_ovf got %b exp 0", over); end
      checks++; if (pcnt !== '0)    begin errors++; $display("FAIL rst_pcnt got %h exp 0", pcnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_frame();
      int d0; bit ok;
      d0 = done_cnt; la.delete(); ld.delete();
      ack = 1; start = 1; tick(); start = 0;
      for (int i = 0; i < NPIX; i++) begin
         valid = 1; data = 24'(i + 1); tick();
      end
      valid = 0;
      wait_done(d0, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout got none exp pulse"); end
      repeat (3) tick();
      checks++; if (la.size() != NPIX) begin errors++; $display("FAIL full_wr_count got %0d exp %0d", la.size(), NPIX); end
      for (int i = 0; i < NPIX && i < la.size(); i++) begin
         checks++; if (la[i] !== AW'(BASE + i)) begin errors++; $display("FAIL full_addr[%0d] got %h exp %h", i, la[i], AW'(BASE + i)); end
         checks++; if (ld[i] !== 32'(i + 1))    begin errors++; $display("FAIL full_data[%0d] got %h exp %h", i, ld[i], 32'(i + 1)); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_cnt - d0); end
      checks++; if (done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL full_done_timing got %0d exp %0d", done_cyc, last_wr_cyc + 1); end
      checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got %b exp 0", done_busy); end
      checks++; if (over !== 1'b0) begin errors++; $display("FAIL full_ovf got %b exp 0", over); end
      checks++; if (pcnt !== AW'(NPIX)) begin errors++; $display("FAIL full_pcnt got %0d exp %0d", pcnt, NPIX); end
   endtask

   task automatic test_overflow();
      int d0; bit ok;
      d0 = done_cnt; la.delete(); ld.delete();
      ack = 0; start = 1; tick(); start = 0;
      for (int i = 0; i < NPIX; i++) begin
         valid = 1; data = 24'('hA0 + i); tick();
         if (i == 3) begin
            checks++; if (over !== 1'b0) begin errors++; $display("FAIL ovf_before_5th got %b exp 0", over); end
         end
         if (i == 4) begin
            checks++; if (over !== 1'b1) begin errors++; $display("FAIL ovf_at_5th got %b exp 1", over); end
         end
      end
      valid = 0; tick();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL ovf_req got %b exp 1", req); end
      checks++; if (addr !== AW'(BASE)) begin errors++; $display("FAIL ovf_head_addr got %h exp %h", addr, AW'(BASE)); end
      checks++; if (wdata !== 32'hA0) begin errors++; $display("FAIL ovf_head_data got %h exp a0", wdata); end
      checks++; if (pcnt !== AW'(NPIX)) begin errors++; $display("FAIL ovf_pcnt got %0d exp %0d", pcnt, NPIX); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", busy); end
      ack = 1;
      wait_done(d0, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout got none exp pulse"); end
      repeat (2) tick();
      checks++; if (la.size() != 4) begin errors++; $display("FAIL ovf_wr_count got %0d exp 4", la.size()); end
      for (int i = 0; i < 4 && i < la.size(); i++) begin
         checks++; if (la[i] !== AW'(BASE + i)) begin errors++; $display("FAIL ovf_addr[%0d] got %h exp %h", i, la[i], AW'(BASE + i)); end
         checks++; if (ld[i] !== 32'('hA0 + i)) begin errors++; $display("FAIL ovf_data[%0d] got %h exp %h", i, ld[i], 32'('hA0 + i)); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ovf_done_count got %0d exp 1", done_cnt - d0); end
   endtask

   task automatic test_idle_valid();
      int d0;
      rst = 1; tick(); rst = 0;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) begin
         valid = 1; data = 24'($urandom); tick();
         checks++; if (req !== 1'b0) begin errors++; $display("FAIL idle_req[%0d] got %b exp 0", i, req); end
         checks++; if (pcnt !== '0)  begin errors++; $display("FAIL idle_pcnt[%0d] got %0d exp 0", i, pcnt); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d] got %b exp 0", i, busy); end
      end
      valid = 0; tick();
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL idle_done got %0d exp 0", done_cnt - d0); end
   endtask

   task automatic test_push_pop_full();
      int d0; bit ok;
      int exp_idx[7] = '{0, 1, 2, 3, 4, 6, 7};
      d0 = done_cnt; la.delete(); ld.delete();
      ack = 0; start = 1; tick(); start = 0;
      for (int i = 0; i < 3; i++) begin
         valid = 1; data = 24'('h300 + i); tick();
      end
      valid = 1; data = 24'h000303; ack = 1; tick();
      checks++; if (over !== 1'b0) begin errors++; $display("FAIL pp_no_drop got %b exp 0", over); end
      checks++; if (addr !== AW'(BASE + 1)) begin errors++; $display("FAIL pp_head_after_pop got %h exp %h", addr, AW'(BASE + 1)); end
      checks++; if (pcnt !== AW'(4)) begin errors++; $display("FAIL pp_pcnt4 got %0d exp 4", pcnt); end
      ack = 0; data = 24'h000304; tick();
      ack = 1; data = 24'h000305; tick();
      checks++; if (over !== 1'b1) begin errors++; $display("FAIL pp_drop_at_full got %b exp 1", over); end
      checks++; if (pcnt !== AW'(6)) begin errors++; $display("FAIL pp_pcnt6 got %0d exp 6", pcnt); end
      data = 24'h000306; tick();
      data = 24'h000307; tick();
      valid = 0;
      wait_done(d0, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL pp_done_timeout got none exp pulse"); end
      checks++; if (la.size() != 7) begin errors++; $display("FAIL pp_wr_count got %0d exp 7", la.size()); end
      for (int i = 0; i < 7 && i < la.size(); i++) begin
         checks++; if (la[i] !== AW'(BASE + exp_idx[i])) begin errors++; $display("FAIL pp_addr[%0d] got %h exp %h", i, la[i], AW'(BASE + exp_idx[i])); end
         checks++; if (ld[i] !== 32'('h300 + exp_idx[i])) begin errors++; $display("FAIL pp_data[%0d] got %h exp %h", i, ld[i], 32'('h300 + exp_idx[i])); end
      end
   endtask

   task automatic test_reset_mid_drain();
      int d0; bit ok;
      ack = 0; start = 1; tick(); start = 0;
      for (int i = 0; i < NPIX; i++) begin
         valid = 1; data = 24'('h500 + i); tick();
      end
      valid = 0; tick();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL rm_req_pre got %b exp 1", req); end
      #2; rst = 1; #1;
      checks++; if (req !== 1'b0)  begin errors++; $display("FAIL rm_req_async got %b exp 0", req); end
      checks++; if (addr !== '0)   begin errors++; $display("FAIL rm_addr got %h exp 0", addr); end
      checks++; if (wdata !== '0)  begin errors++; $display("FAIL rm_data got %h exp 0", wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
      checks++; if (over !== 1'b0) begin errors++; $display("FAIL rm_ovf got %b exp 0", over); end
      checks++; if (pcnt !== '0)   begin errors++; $display("FAIL rm_pcnt got %h exp 0", pcnt); end
      tick(); rst = 0;
      d0 = done_cnt; la.delete(); ld.delete();
      start = 1; tick(); start = 0;
      valid = 1; data = 24'h000600; tick(); valid = 0; tick();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL rm_new_req got %b exp 1", req); end
      checks++; if (addr !== AW'(BASE)) begin errors++; $display("FAIL rm_new_addr got %h exp %h", addr, AW'(BASE)); end
      checks++; if (wdata !== 32'h600) begin errors++; $display("FAIL rm_new_data got %h exp 600", wdata); end
      ack = 1;
      for (int i = 1; i < NPIX; i++) begin
         valid = 1; data = 24'('h600 + i); tick();
      end
      valid = 0;
      wait_done(d0, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_done_timeout got none exp pulse"); end
      checks++; if (la.size() != NPIX) begin errors++; $display("FAIL rm_wr_count got %0d exp %0d", la.size(), NPIX); end
      for (int i = 0; i < NPIX && i < la.size(); i++) begin
         checks++; if (la[i] !== AW'(BASE + i)) begin errors++; $display("FAIL rm_addr[%0d] got %h exp %h", i, la[i], AW'(BASE + i)); end
      end
   endtask

   task automatic test_start_mid_capture();
      int d0; bit ok;
      d0 = done_cnt; la.delete(); ld.delete();
      ack = 1; start = 1; tick(); start = 0;
      for (int i = 0; i < NPIX; i++) begin
         valid = 1; data = 24'('h700 + i); start = (i == 3); tick();
         checks++; if (pcnt !== AW'(i + 1)) begin errors++; $display("FAIL smc_pcnt[%0d] got %0d exp %0d", i, pcnt, i + 1); end
      end
      start = 0; valid = 0;
      wait_done(d0, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL smc_done_timeout got none exp pulse"); end
      checks++; if (la.size() != NPIX) begin errors++; $display("FAIL smc_wr_count got %0d exp %0d", la.size(), NPIX); end
      for (int i = 0; i < NPIX && i < la.size(); i++) begin
         checks++; if (la[i] !== AW'(BASE + i)) begin errors++; $display("FAIL smc_addr[%0d] got %h exp %h", i, la[i], AW'(BASE + i)); end
         checks++; if (ld[i] !== 32'('h700 + i)) begin errors++; $display("FAIL smc_data[%0d] got %h exp %h", i, ld[i], 32'('h700 + i)); end
      end
   endtask

   task automatic test_random();
      bit settled;
      for (int c = 0; c < 600; c++) begin
         start = ($urandom_range(0, 7) == 0);
         valid = ($urandom_range(0, 3) != 0);
         data  = 24'($urandom);
         ack   = $urandom_range(0, 1);
         if (c >= 560) begin start = 0; ack = 1; end
         tick();
         checks++; if (req !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_req@%0d got %b exp %b", c, req, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            checks++; if (addr !== m_q[0][35:24]) begin errors++; $display("FAIL rnd_addr@%0d got %h exp %h", c, addr, m_q[0][35:24]); end
            checks++; if (wdata !== {8'h00, m_q[0][23:0]}) begin errors++; $display("FAIL rnd_data@%0d got %h exp %h", c, wdata, {8'h00, m_q[0][23:0]}); end
         end
         checks++; if (over !== m_over) begin errors++; $display("FAIL rnd_ovf@%0d got %b exp %b", c, over, m_over); end
         checks++; if (pcnt !== AW'(m_idx)) begin errors++; $display("FAIL rnd_pcnt@%0d got %0d exp %0d", c, pcnt, m_idx); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy@%0d got %b exp %b", c, busy, m_busy); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done@%0d got %b exp %b", c, done, m_done); end
      end
      valid = 0;
      settled = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_phase == 0 && !busy) begin settled = 1; break; end
      end
      checks++; if (!settled) begin errors++; $display("FAIL rnd_settle got busy=%b exp idle", busy); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL rnd_final_req got %b exp 0", req); end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; start = 0; valid = 0; data = '0; ack = 0;
      test_reset();
      test_full_frame();
      test_overflow();
      test_idle_valid();
      test_push_pop_full();
      test_reset_mid_drain();
      test_start_mid_capture();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
